// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions used by the receive and transmit sides.
// Provides the byte-FSM state encoding and the clocks-per-bit helper.
package uart_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    function automatic int clks_per_bit(
        input int clk_freq,
        input int baud
    );
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 byte receiver with input synchronizer and bit timing.
// Ports: clk, rst_n, rxd in; byte_data, byte_valid, byte_err, start_edge, idle out.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       byte_err,
    output logic       start_edge,
    output logic       idle
);

    localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
    localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;

    localparam logic [CW-1:0] HALF = CW'(CPB / 2);
    localparam logic [CW-1:0] LAST = CW'(CPB - 1);

    logic          rx_meta;
    logic          rx_sync;
    logic          rx_prev;
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    assign idle       = (state == ST_IDLE);
    assign start_edge = idle & rx_prev & ~rx_sync;
    assign byte_data  = shreg;

    // Line idles high, so the synchronizer resets to 1 to avoid a
    // spurious start edge coming out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            byte_err   <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            byte_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_edge) begin
                        state <= ST_START;
                        cnt   <= '0;
                    end
                end
                ST_START: begin
                    if (cnt == HALF) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        if (rx_sync) begin
                            state    <= ST_IDLE;
                            byte_err <= 1'b1;
                        end else begin
                            state <= ST_DATA;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        shreg <= {rx_sync, shreg[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                        if (rx_sync) begin
                            byte_valid <= 1'b1;
                        end else begin
                            byte_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_deser64.sv
// uart_rx_deser64: assembles eight received UART bytes into a 64-bit word.
// Ports: clk, rst_n, uart_rxd in; data_64, data_valid, frame_err out.
module uart_rx_deser64
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD         = 115200,
    parameter int TIMEOUT_BITS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rxd,
    output logic [63:0] data_64,
    output logic        data_valid,
    output logic        frame_err
);

    localparam int CPB     = clks_per_bit(CLK_FREQ, BAUD);
    localparam int TO_CLKS = TIMEOUT_BITS * CPB;
    localparam int TW      = $clog2(TO_CLKS + 1);

    localparam logic [TW-1:0] TO_LAST = TW'(TO_CLKS - 1);

    logic [7:0]    byte_data;
    logic          byte_valid;
    logic          byte_err;
    logic          start_edge;
    logic          rx_idle;
    logic [2:0]    byte_cnt;
    logic [63:0]   asm_word;
    logic [TW-1:0] to_cnt;
    logic          timeout_hit;

    uart_rx_byte #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_rx_byte (
        .clk        (clk),
        .rst_n      (rst_n),
        .rxd        (uart_rxd),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_err   (byte_err),
        .start_edge (start_edge),
        .idle       (rx_idle)
    );

    // A start edge in the expiry cycle wins, keeping the partial word.
    assign timeout_hit = rx_idle && (byte_cnt != 3'd0) &&
                         !start_edge && (to_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt   <= '0;
            asm_word   <= '0;
            to_cnt     <= '0;
            data_64    <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;

            if (byte_valid) begin
                asm_word[{byte_cnt, 3'b000} +: 8] <= byte_data;
                // 3-bit count wraps to 0 after the eighth byte.
                byte_cnt <= byte_cnt + 1'b1;
                if (byte_cnt == 3'd7) begin
                    data_64    <= {byte_data, asm_word[55:0]};
                    data_valid <= 1'b1;
                end
            end else if (byte_err) begin
                byte_cnt  <= '0;
                frame_err <= 1'b1;
            end else if (timeout_hit) begin
                byte_cnt <= '0;
            end

            if (!rx_idle || byte_cnt == 3'd0 ||
                start_edge || timeout_hit) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_deser64.sv
// tb_uart_rx_deser64: randomized and directed bench for the word receiver.
// A byte-queue reference model predicts words and frame-error counts.
`timescale 1ns/1ps
module tb_uart_rx_deser64;

    localparam int CLK_FREQ     = 1600000;
    localparam int BAUD         = 100000;
    localparam int TIMEOUT_BITS = 16;
    localparam int CPB          = CLK_FREQ / BAUD;
    localparam int BIT_NS       = CPB * 10;

    logic        clk;
    logic        rst_n;
    logic        rxd;
    logic [63:0] data_64;
    logic        data_valid;
    logic        frame_err;

    uart_rx_deser64 #(
        .CLK_FREQ     (CLK_FREQ),
        .BAUD         (BAUD),
        .TIMEOUT_BITS (TIMEOUT_BITS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .uart_rxd   (rxd),
        .data_64    (data_64),
        .data_valid (data_valid),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_pass;

    logic [7:0]  mq[$];
    logic [63:0] exp_q[$];
    int          exp_err;

    logic [63:0] got_q[$];
    int          ecnt;
    int          both_cnt;
    int          hold_err;
    logic [63:0] prev_d;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_d = 64'd0;
        end else begin
            if (data_valid) got_q.push_back(data_64);
            if (frame_err) ecnt++;
            if (data_valid && frame_err) both_cnt++;
            if (!data_valid && data_64 !== prev_d) hold_err++;
            prev_d = data_64;
        end
    end

    task automatic chk(
        input string       tag,
        input logic [63:0] got,
        input logic [63:0] exp
    );
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            #(BIT_NS);
        end
        rxd = stop;
        #(BIT_NS);
        rxd = 1'b1;
    endtask

    task automatic send_good(input logic [7:0] b);
        logic [63:0] w;
        drive_frame(b, 1'b1);
        mq.push_back(b);
        if (mq.size() == 8) begin
            w = '0;
            for (int i = 0; i < 8; i++) w[i*8 +: 8] = mq[i];
            exp_q.push_back(w);
            mq.delete();
        end
    endtask

    task automatic send_bad(input logic [7:0] b);
        drive_frame(b, 1'b0);
        #(BIT_NS);
        mq.delete();
        exp_err++;
    endtask

    task automatic gap(input int n);
        rxd = 1'b1;
        #(n * BIT_NS);
        if (n > TIMEOUT_BITS) mq.delete();
    endtask

    task automatic glitch();
        rxd = 1'b0;
        #(BIT_NS * 3 / 10);
        rxd = 1'b1;
        #(2 * BIT_NS);
        exp_err++;
    endtask

    function automatic logic [63:0] last_got();
        if (got_q.size() == 0) return 64'd0;
        return got_q[got_q.size()-1];
    endfunction

    task automatic check_scn(input string tag);
        int n;
        gap(3);
        chk({tag, "_nvalid"}, 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_word%0d", tag, i), got_q[i], exp_q[i]);
        chk({tag, "_ferr"}, 64'(ecnt), 64'(exp_err));
        chk({tag, "_excl"}, 64'(both_cnt), 64'd0);
        chk({tag, "_hold"}, 64'(hold_err), 64'd0);
        got_q.delete();
        exp_q.delete();
        ecnt     = 0;
        exp_err  = 0;
        both_cnt = 0;
        hold_err = 0;
    endtask

    initial begin
        logic [63:0] w;
        logic [7:0]  b;
        n_chk    = 0;
        n_pass   = 0;
        exp_err  = 0;
        ecnt     = 0;
        both_cnt = 0;
        hold_err = 0;
        rxd      = 1'b1;
        rst_n    = 1'b0;
        #33;
        chk("rst_data", data_64, 64'd0);
        chk("rst_valid", 64'(data_valid), 64'd0);
        chk("rst_ferr", 64'(frame_err), 64'd0);
        rst_n = 1'b1;
        gap(2);

        for (int i = 1; i <= 8; i++) begin
            send_good(8'(i));
            gap(1);
        end
        w = last_got();
        check_scn("seq");
        chk("seq_lit", w, 64'h0807060504030201);

        send_bad(8'hAA);
        for (int i = 1; i <= 8; i++) send_good(8'(i * 8'h11));
        w = last_got();
        check_scn("badstop");
        chk("badstop_lit", w, 64'h8877665544332211);

        glitch();
        check_scn("glitch");

        for (int i = 0; i < 3; i++) send_good(8'($urandom));
        gap(20);
        for (int i = 0; i < 8; i++) send_good(8'hF0 + 8'(i));
        w = last_got();
        check_scn("timeout");
        chk("timeout_lit", w, 64'hF7F6F5F4F3F2F1F0);

        for (int i = 0; i < 3; i++) send_good(8'($urandom));
        b = 8'($urandom);
        rxd = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            rxd = b[i];
            #(BIT_NS);
        end
        rxd = b[4];
        #(BIT_NS / 2 + 3);
        rst_n = 1'b0;
        #1;
        chk("midrst_data", data_64, 64'd0);
        chk("midrst_valid", 64'(data_valid), 64'd0);
        chk("midrst_ferr", 64'(frame_err), 64'd0);
        rxd = 1'b1;
        mq.delete();
        #(BIT_NS);
        rst_n = 1'b1;
        gap(2);
        for (int i = 0; i < 8; i++) send_good(8'($urandom));
        check_scn("midrst");

        for (int i = 0; i < 16; i++) send_good(8'($urandom));
        check_scn("b2b");

        for (int i = 0; i < 40; i++) begin
            b = 8'($urandom);
            if ($urandom_range(0, 5) == 0) send_bad(b);
            else send_good(b);
            if ($urandom_range(0, 12) == 0) gap(20);
            else gap($urandom_range(0, 2));
        end
        check_scn("rand");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_rx_deser64.md
UART_RX_DESER64 -- requirements
Module: uart_rx_deser64

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning line bit rate.
REQ-003 SHALL have parameter TIMEOUT_BITS, default 16, meaning idle bit-times that abort a partial word.
REQ-004 SHALL have port clk, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port uart_rxd, input, 1 bit: serial line, idle high, 8N1, asynchronous to clk.
REQ-007 SHALL have port data_64, output, 64 bits: last completely received word.
REQ-008 SHALL have port data_valid, output, 1 bit: one-cycle pulse when data_64 updates.
REQ-009 SHALL have port frame_err, output, 1 bit: one-cycle pulse on bad stop bit or false start.

Function
REQ-010 SHALL pass uart_rxd through a two-flop synchronizer (reset value 1) before any use.
REQ-011 SHALL use CLKS_PER_BIT = CLK_FREQ/BAUD (integer division; 434 at defaults) and a bit-period counter sized by $clog2.
REQ-012 SHALL implement states IDLE, START, DATA, STOP.
REQ-013 IDLE -> START on a 1-to-0 transition of the synchronized line; the bit counter is cleared.
REQ-014 In START, at CLKS_PER_BIT/2 the line SHALL be sampled: 0 -> DATA; 1 -> IDLE with frame_err pulse.
REQ-015 In DATA, 8 bits SHALL be sampled, LSB first, one every CLKS_PER_BIT from the start-bit midpoint.
REQ-016 In STOP, the line SHALL be sampled at the bit midpoint: 1 -> byte accepted; 0 -> byte discarded, byte count cleared, frame_err pulse. Both cases return to IDLE.
REQ-017 Accepted bytes SHALL be packed first-received into data bits [7:0], the eighth into [63:56], in a shift/assembly register separate from data_64.
REQ-018 On the eighth accepted byte, data_64 SHALL load the assembled word and data_valid SHALL pulse on the next clk edge after the stop-bit sample (latency 1 clk); the byte count then wraps to 0.
REQ-019 data_64 SHALL hold its value between words; frame errors and timeouts never modify it.
REQ-020 In IDLE with byte count 1..7, if TIMEOUT_BITS*CLKS_PER_BIT clocks elapse without a start edge, byte count SHALL clear silently (no frame_err).
REQ-021 A start edge arriving in the same cycle as timeout expiry SHALL take precedence: the partial word is kept and reception proceeds.
REQ-022 data_valid and frame_err SHALL never assert in the same cycle.

Reset
REQ-023 On rst_n low, asynchronously: state IDLE, all counters 0, synchronizer flops 1, assembly register 0, data_64 = 0, data_valid = 0, frame_err = 0.
REQ-024 Reset asserted mid-frame SHALL discard any partial byte and word; after release, the next byte is treated as byte 0 only after a fresh high-to-low start edge.

Structure
REQ-025 SHALL place the state encoding (IDLE/START/DATA/STOP) and the CLKS_PER_BIT helper function in shared package uart_pkg, reused by the transmitter side.
REQ-026 SHALL instantiate one sub-module, uart_rx_byte (sync, bit timing, 8N1 byte FSM, byte_valid/byte_err outputs); word assembly and timeout live in the parent.

Verification
REQ-027 Send bytes 0x01..0x08 at 115200 -> one data_valid pulse, data_64 = 0x0807060504030201, frame_err never asserted.
REQ-028 Send 0xAA with stop bit forced 0 -> frame_err pulses once; then send 8 good bytes 0x11..0x88 -> data_64 = 0x8877665544332211.
REQ-029 Send a 0.3-bit-time low glitch on an idle line -> frame_err pulses once, no data_valid, state returns to IDLE.
REQ-030 Send 3 bytes, idle 20 bit-times, send 0xF0..0xF7 -> data_64 = 0xF7F6F5F4F3F2F1F0 (partial word dropped).
REQ-031 Assert rst_n low during the 5th data bit of byte 4 -> all outputs 0 immediately; afterwards 8 fresh bytes yield a correct word.
REQ-032 Send two words back-to-back with no inter-frame gap -> two data_valid pulses, each data_64 value correct and held until the next pulse.
